game_mode_ctrl: RTL

//  Top-level game-mode sequencer for the tile-matching game. Successor of the single-level mode FSM:

---
 rtl/game_pkg.sv | 36 +++
 rtl/key_edge_detect.sv | 31 +++
 rtl/game_mode_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the tile-matching game: mode codes and the
// active-low 7-segment patterns shown on HEX0 for each mode digit.
// Also used by the VGA and scoring blocks.
package game_pkg;

    typedef enum logic [2:0] {
        MODE_MENU        = 3'd0,
        MODE_INGAME      = 3'd1,
        MODE_ENDGAME     = 3'd2,
        MODE_PAUSED      = 3'd3,
        MODE_LEVELUP     = 3'd4,
        MODE_LEADERBOARD = 3'd5
    } mode_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;

    // Codes 6 and 7 never occur; they display as MENU.
    function automatic logic [6:0] mode_seg(input mode_e m);
        case (m)
            MODE_MENU:        mode_seg = SEG_0;
            MODE_INGAME:      mode_seg = SEG_1;
            MODE_ENDGAME:     mode_seg = SEG_2;
            MODE_PAUSED:      mode_seg = SEG_3;
            MODE_LEVELUP:     mode_seg = SEG_4;
            MODE_LEADERBOARD: mode_seg = SEG_5;
            default:          mode_seg = SEG_0;
        endcase
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one debounced, level-sensitive key.
// The key is registered once (key_s) and again (key_q); rise is high for one
// cycle after the first edge that samples the key high. A held key fires once.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset, clears key history
//   key   in  debounced key level
//   rise  out one-cycle pulse on a sampled 0->1 transition
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic key_s;
    logic key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s <= 1'b0;
            key_q <= 1'b0;
        end else begin
            key_s <= key;
            key_q <= key_s;
        end
    end

    assign rise = key_s & ~key_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// Top-level game-mode sequencer: MENU -> INGAME <-> PAUSED, level progression
// through LEVELUP, ENDGAME, and a leaderboard screen with timeout.
// All outputs are registered and decoded from the next mode, so they change
// on the same edge as mode.
// Ports:
//   CLOCK_50      in  system clock
//   userquit      in  synchronous active-high reset
//   keytobegin    in  start/confirm key (debounced level)
//   keypause      in  pause toggle key (debounced level)
//   levelCleared  in  board cleared, from in-game logic
//   gameOver      in  loss condition, from in-game logic
//   ingameOn      out high only in INGAME
//   levelStart    out one-cycle pulse on entry to INGAME from MENU or LEVELUP
//   gameWon       out high in ENDGAME reached by clearing the final level
//   level         out current level, 0-based
//   mode          out current mode code
//   hex0holder    out active-low 7-segment pattern of the mode digit
module game_mode_ctrl #(
    parameter int NUM_LEVELS  = 4,
    parameter int LEVELUP_CYC = 50_000_000,
    parameter int LB_TIMEOUT  = 250_000_000,
    parameter int LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             CLOCK_50,
    input  logic             userquit,
    input  logic             keytobegin,
    input  logic             keypause,
    input  logic             levelCleared,
    input  logic             gameOver,
    output logic             ingameOn,
    output logic             levelStart,
    output logic             gameWon,
    output logic [LVL_W-1:0] level,
    output logic [2:0]       mode,
    output logic [6:0]       hex0holder
);

    import game_pkg::*;

    // One counter serves both timed modes; it is cleared on every mode change.
    localparam int CNT_MAX = (LEVELUP_CYC > LB_TIMEOUT) ? LEVELUP_CYC : LB_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LU_LAST  = CNT_W'(LEVELUP_CYC - 1);
    localparam logic [CNT_W-1:0] LB_LAST  = CNT_W'(LB_TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS - 1);

    mode_e            state;
    mode_e            next;
    logic [CNT_W-1:0] cnt;
    logic             begin_rise;
    logic             pause_rise;
    logic             lvl_inc;
    logic             lvl_clr;
    logic             won_set;
    logic             won_clr;
    logic             start;

    key_edge_detect u_begin_edge (
        .clk  (CLOCK_50),
        .rst  (userquit),
        .key  (keytobegin),
        .rise (begin_rise)
    );

    key_edge_detect u_pause_edge (
        .clk  (CLOCK_50),
        .rst  (userquit),
        .key  (keypause),
        .rise (pause_rise)
    );

    always_comb begin
        next    = state;
        lvl_inc = 1'b0;
        lvl_clr = 1'b0;
        won_set = 1'b0;
        won_clr = 1'b0;
        start   = 1'b0;
        case (state)
            MODE_MENU: begin
                if (begin_rise) begin
                    next    = MODE_INGAME;
                    lvl_clr = 1'b1;
                    won_clr = 1'b1;
                    start   = 1'b1;
                end
            end
            MODE_INGAME: begin
                // A loss in the same cycle as a clear still counts as a loss.
                if (gameOver) begin
                    next    = MODE_ENDGAME;
                    won_clr = 1'b1;
                end else if (levelCleared) begin
                    if (level == LVL_LAST) begin
                        next    = MODE_ENDGAME;
                        won_set = 1'b1;
                    end else begin
                        next = MODE_LEVELUP;
                    end
                end else if (pause_rise) begin
                    next = MODE_PAUSED;
                end
            end
            MODE_PAUSED: begin
                // Resuming is not a new level start, so no levelStart pulse.
                if (pause_rise) next = MODE_INGAME;
            end
            MODE_LEVELUP: begin
                if (cnt == LU_LAST) begin
                    next    = MODE_INGAME;
                    lvl_inc = 1'b1;
                    start   = 1'b1;
                end
            end
            MODE_ENDGAME: begin
                if (begin_rise) next = MODE_LEADERBOARD;
            end
            MODE_LEADERBOARD: begin
                if (begin_rise || cnt == LB_LAST) begin
                    next    = MODE_MENU;
                    lvl_clr = 1'b1;
                    won_clr = 1'b1;
                end
            end
            default: next = MODE_MENU;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state      <= MODE_MENU;
            cnt        <= '0;
            level      <= '0;
            gameWon    <= 1'b0;
            ingameOn   <= 1'b0;
            levelStart <= 1'b0;
            hex0holder <= SEG_0;
        end else begin
            state <= next;
            if (next != state || !(state == MODE_LEVELUP || state == MODE_LEADERBOARD))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (lvl_clr)
                level <= '0;
            else if (lvl_inc)
                level <= level + LVL_W'(1);
            if (won_clr)
                gameWon <= 1'b0;
            else if (won_set)
                gameWon <= 1'b1;
            ingameOn   <= (next == MODE_INGAME);
            levelStart <= start;
            hex0holder <= mode_seg(next);
        end
    end

    assign mode = state;

endmodule
